// File: rtl/gx4000_chan_io_if.sv
// gx4000_chan_io_if: CPU I/O port bus between the host decoder and the channel block.
interface gx4000_chan_io_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_wr;
  logic        cpu_rd;
  logic [7:0]  io_dout;
  logic        io_sel;
  modport master(output cpu_addr, cpu_data, cpu_wr, cpu_rd, input io_dout, io_sel);
  modport slave(input cpu_addr, cpu_data, cpu_wr, cpu_rd, output io_dout, io_sel);
endinterface

// File: rtl/gx4000_chan_io.sv
// gx4000_chan_io: CPU-addressed output channels, each a byte FIFO drained by a strobe/ack FSM.
module gx4000_chan_io #(
  parameter int         NUM_CH    = 4,
  parameter int         DEPTH     = 8,
  parameter logic [7:0] BASE_ADDR = 8'h70,
  parameter int         TIMEOUT   = 255
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                enable,
  gx4000_chan_io_if.slave     bus,
  output logic [8*NUM_CH-1:0] ch_data,
  output logic [NUM_CH-1:0]   ch_strobe,
  input  logic [NUM_CH-1:0]   ch_ack,
  output logic                irq
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, STROBE, RELEASE} state_t;
  logic [8:0] w_off;
  logic [2:0] w_ch;
  logic w_hit, w_port, w_unused;
  logic [NUM_CH-1:0] w_empty, w_full, w_idle, w_ovf, w_tmo, w_ien;
  logic [7:0][7:0] w_stat8, w_data8;
  logic r_irq;
  // 9-bit offset so addresses below BASE_ADDR show up as negative and miss
  assign w_off = {1'b0, bus.cpu_addr[7:0]} - {1'b0, BASE_ADDR};
  assign w_hit = enable && !w_off[8] && w_off < 9'(2 * NUM_CH);
  assign w_ch = w_off[3:1];
  assign w_port = w_off[0];
  assign w_unused = ^bus.cpu_addr[15:8];
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t r_st, w_nst;
    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_data;
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0] r_cnt;
    logic [15:0] r_tmr;
    logic r_ovf, r_tmo, r_ien, r_stb;
    logic w_sel, w_dwr, w_cwr, w_clr, w_flush, w_push, w_pop, w_tout;
    assign w_sel = w_hit && bus.cpu_wr && w_ch == 3'(c);
    assign w_dwr = w_sel && !w_port;
    assign w_cwr = w_sel && w_port;
    assign w_flush = w_cwr && bus.cpu_data[0];
    assign w_clr = w_cwr && bus.cpu_data[1];
    assign w_push = w_dwr && !w_full[c] && !w_flush;
    always_ff @(posedge clk_sys or posedge reset)
      if (reset) r_st <= IDLE;
      else r_st <= w_nst;
    always_comb
      w_nst = r_st == IDLE ? (w_empty[c] ? IDLE : STROBE)
            : r_st == STROBE ? (ch_ack[c] ? RELEASE : (w_tout ? IDLE : STROBE))
            : (ch_ack[c] ? RELEASE : IDLE);
    always_comb begin
      w_pop = r_st == IDLE && !w_empty[c];
      w_tout = r_st == STROBE && !ch_ack[c] && r_tmr == 16'(TIMEOUT - 1);
    end
    always_ff @(posedge clk_sys)
      if (w_push) r_mem[r_wp] <= bus.cpu_data;
    // flush resets the queue only; a byte already loaded into r_data finishes its handshake
    always_ff @(posedge clk_sys or posedge reset)
      if (reset) begin
        r_wp <= '0;
        r_rp <= '0;
        r_cnt <= '0;
        r_tmr <= '0;
        r_data <= '0;
        r_ovf <= 1'b0;
        r_tmo <= 1'b0;
        r_ien <= 1'b0;
        r_stb <= 1'b0;
      end else begin
        r_wp <= w_flush ? '0 : r_wp + AW'(w_push);
        r_rp <= w_flush ? '0 : r_rp + AW'(w_pop);
        r_cnt <= w_flush ? '0 : r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        r_tmr <= w_pop ? '0 : (r_st == STROBE ? r_tmr + 16'd1 : r_tmr);
        r_data <= w_pop ? r_mem[r_rp] : r_data;
        r_ovf <= (w_dwr && w_full[c]) || (r_ovf && !w_clr);
        r_tmo <= w_tout || (r_tmo && !w_clr);
        r_ien <= w_cwr ? bus.cpu_data[2] : r_ien;
        r_stb <= w_nst == STROBE;
      end
    assign w_empty[c] = r_cnt == '0;
    assign w_full[c] = r_cnt == (AW+1)'(DEPTH);
    assign w_idle[c] = r_st == IDLE;
    assign w_ovf[c] = r_ovf;
    assign w_tmo[c] = r_tmo;
    assign w_ien[c] = r_ien;
    assign ch_data[8*c +: 8] = r_data;
    assign ch_strobe[c] = r_stb;
  end
  always_comb begin
    w_stat8 = '1;
    w_data8 = '1;
    for (int i = 0; i < NUM_CH; i++) begin
      w_stat8[i] = {w_ien[i], 2'b00, w_ovf[i], w_tmo[i], !w_idle[i], w_full[i], w_empty[i]};
      w_data8[i] = ch_data[8*i +: 8];
    end
  end
  assign bus.io_dout = !w_hit ? 8'hFF : (w_port ? w_stat8[w_ch] : w_data8[w_ch]);
  assign bus.io_sel = w_hit && bus.cpu_rd;
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) r_irq <= 1'b0;
    else r_irq <= |(w_ien & ((w_empty & w_idle) | w_ovf | w_tmo));
  assign irq = r_irq;
endmodule

// File: tb/tb_gx4000_chan_io.sv
// tb_gx4000_chan_io: decode vector table, per-channel byte scoreboard and timing sequences.
module tb_gx4000_chan_io;
  logic clk_sys = 1'b0, reset = 1'b1, enable = 1'b1;
  logic [3:0] ch_ack, ch_strobe, man_ack = '0, auto_en = '0, auto_ack = '0, prev_stb = '0;
  logic [31:0] ch_data;
  logic irq, ack2 = 1'b0, strobe2, irq2;
  logic [7:0] data2;
  int checks = 0, errors = 0;
  int lat [4] = '{1, 1, 1, 1};
  int cnt [4] = '{0, 0, 0, 0};
  logic [7:0] sb [4][$];
  typedef struct {logic [15:0] addr; logic en; logic rd; logic [7:0] dout; logic sel;} vec_t;
  vec_t vt [11];
  gx4000_chan_io_if bif ();
  gx4000_chan_io_if bif2 ();
  assign ch_ack = man_ack | auto_ack;
  assign bif2.cpu_addr = bif.cpu_addr;
  assign bif2.cpu_data = bif.cpu_data;
  assign bif2.cpu_wr = bif.cpu_wr;
  assign bif2.cpu_rd = bif.cpu_rd;
  gx4000_chan_io u_dut (.clk_sys(clk_sys), .reset(reset), .enable(enable), .bus(bif),
    .ch_data(ch_data), .ch_strobe(ch_strobe), .ch_ack(ch_ack), .irq(irq));
  gx4000_chan_io #(.NUM_CH(1), .DEPTH(4), .BASE_ADDR(8'h80), .TIMEOUT(4)) u_tmo (
    .clk_sys(clk_sys), .reset(reset), .enable(enable), .bus(bif2),
    .ch_data(data2), .ch_strobe(strobe2), .ch_ack(ack2), .irq(irq2));
  always #5 clk_sys = ~clk_sys;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask
  // ack responder and in-order byte scoreboard, one lane per channel
  always @(negedge clk_sys) begin
    for (int c = 0; c < 4; c++) begin
      cnt[c] = ch_strobe[c] ? cnt[c] + 1 : 0;
      auto_ack[c] = auto_en[c] && ch_strobe[c] && cnt[c] > lat[c];
      if (ch_strobe[c] && !prev_stb[c]) begin
        if (sb[c].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_ch%0d actual %0h required no_byte", c, ch_data[8*c +: 8]);
        end else chk($sformatf("sb_ch%0d", c), 32'(ch_data[8*c +: 8]), 32'(sb[c].pop_front()));
      end
    end
    prev_stb = ch_strobe;
  end
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bif.cpu_addr = {8'h00, a};
    bif.cpu_data = d;
    bif.cpu_wr = 1'b1;
    @(negedge clk_sys);
    bif.cpu_wr = 1'b0;
  endtask
  task automatic push(input int c, input logic [7:0] d, input bit keep);
    if (keep) sb[c].push_back(d);
    wr(8'h70 + 8'(2 * c), d);
  endtask
  task automatic rchk(input string name, input logic [15:0] a, input logic [7:0] exp);
    bif.cpu_addr = a;
    bif.cpu_rd = 1'b1;
    #1;
    chk(name, 32'(a[7] ? bif2.io_dout : bif.io_dout), 32'(exp));
    bif.cpu_rd = 1'b0;
  endtask
  task automatic cycles(input int n);
    repeat (n) @(negedge clk_sys);
  endtask
  task automatic drain(input string name);
    int t = 0;
    while ((sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size() != 0 || ch_strobe != 0) && t < 400) begin
      @(negedge clk_sys);
      t++;
    end
    chk({name, "_drain"}, 32'(t < 400), 1);
    cycles(2);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1);
  end
  initial begin
    vt[0] = '{16'h0070, 1'b1, 1'b1, 8'h00, 1'b1};
    vt[1] = '{16'h0071, 1'b1, 1'b1, 8'h01, 1'b1};
    vt[2] = '{16'h0077, 1'b1, 1'b1, 8'h01, 1'b1};
    vt[3] = '{16'h0076, 1'b1, 1'b1, 8'h00, 1'b1};
    vt[4] = '{16'h0078, 1'b1, 1'b1, 8'hFF, 1'b0};
    vt[5] = '{16'h006F, 1'b1, 1'b1, 8'hFF, 1'b0};
    vt[6] = '{16'hAB71, 1'b1, 1'b1, 8'h01, 1'b1};
    vt[7] = '{16'h0071, 1'b1, 1'b0, 8'h01, 1'b0};
    vt[8] = '{16'h0071, 1'b0, 1'b1, 8'hFF, 1'b0};
    vt[9] = '{16'h0081, 1'b1, 1'b1, 8'h01, 1'b1};
    vt[10] = '{16'h0082, 1'b1, 1'b1, 8'hFF, 1'b0};
    bif.cpu_addr = '0;
    bif.cpu_data = '0;
    bif.cpu_wr = 1'b0;
    bif.cpu_rd = 1'b0;
    cycles(3);
    chk("rst_strobe", 32'({strobe2, ch_strobe}), 0);
    chk("rst_irq", 32'({irq2, irq}), 0);
    chk("rst_data", ch_data, 0);
    reset = 1'b0;
    @(negedge clk_sys);
    for (int i = 0; i < 11; i++) begin
      enable = vt[i].en;
      bif.cpu_addr = vt[i].addr;
      bif.cpu_rd = vt[i].rd;
      #1;
      chk($sformatf("vec%0d_dout", i), 32'(vt[i].addr[7] ? bif2.io_dout : bif.io_dout), 32'(vt[i].dout));
      chk($sformatf("vec%0d_sel", i), 32'(vt[i].addr[7] ? bif2.io_sel : bif.io_sel), 32'(vt[i].sel));
      @(negedge clk_sys);
    end
    enable = 1'b1;
    bif.cpu_rd = 1'b0;
    // single byte with a hand-driven ack at n+4 held for two cycles
    push(0, 8'hA5, 1);
    chk("one_stb_n1", 32'(ch_strobe[0]), 0);
    @(negedge clk_sys);
    chk("one_stb_n2", 32'(ch_strobe[0]), 1);
    chk("one_data", 32'(ch_data[7:0]), 'hA5);
    @(negedge clk_sys);
    chk("one_stb_n3", 32'(ch_strobe[0]), 1);
    @(negedge clk_sys);
    man_ack[0] = 1'b1;
    chk("one_stb_n4", 32'(ch_strobe[0]), 1);
    @(negedge clk_sys);
    chk("one_stb_n5", 32'(ch_strobe[0]), 0);
    @(negedge clk_sys);
    man_ack[0] = 1'b0;
    rchk("one_release", 16'h0071, 8'h05);
    @(negedge clk_sys);
    rchk("one_idle", 16'h0071, 8'h01);
    // overflow: 9 back-to-back writes fill 1 in flight + 8 queued, the 10th is dropped
    for (int i = 0; i < 9; i++) push(1, 8'h10 + 8'(i), 1);
    rchk("ovf_full", 16'h0073, 8'h06);
    push(1, 8'h19, 0);
    rchk("ovf_set", 16'h0073, 8'h16);
    auto_en = 4'hF;
    drain("ovf");
    rchk("ovf_after", 16'h0073, 8'h11);
    wr(8'h73, 8'h02);
    rchk("ovf_clr", 16'h0073, 8'h01);
    // timeout on the TIMEOUT=4 instance, ack never driven
    wr(8'h81, 8'h04);
    @(negedge clk_sys);
    chk("tmo_irq_empty", 32'(irq2), 1);
    wr(8'h80, 8'h3C);
    chk("tmo_stb_n1", 32'(strobe2), 0);
    for (int k = 2; k <= 6; k++) begin
      @(negedge clk_sys);
      chk($sformatf("tmo_stb_n%0d", k), 32'(strobe2), 32'(k < 6));
    end
    chk("tmo_data", 32'(data2), 'h3C);
    chk("tmo_irq_n6", 32'(irq2), 0);
    rchk("tmo_status", 16'h0081, 8'h89);
    @(negedge clk_sys);
    chk("tmo_irq_n7", 32'(irq2), 1);
    wr(8'h81, 8'h06);
    rchk("tmo_clr", 16'h0081, 8'h81);
    wr(8'h81, 8'h02);
    @(negedge clk_sys);
    chk("tmo_irq_off", 32'(irq2), 0);
    rchk("tmo_final", 16'h0081, 8'h01);
    // interleaved channels 0 and 3 with different ack latencies
    lat = '{0, 1, 1, 4};
    for (int i = 0; i < 6; i++) begin
      push(0, 8'h40 + 8'(i), 1);
      push(3, 8'hC0 + 8'(i), 1);
    end
    drain("indep");
    // push and pop in the same cycle with three bytes queued
    auto_en[2] = 1'b0;
    for (int i = 0; i < 4; i++) push(2, 8'h60 + 8'(i), 1);
    man_ack[2] = 1'b1;
    @(negedge clk_sys);
    man_ack[2] = 1'b0;
    @(negedge clk_sys);
    push(2, 8'h64, 1);
    for (int i = 5; i < 9; i++) push(2, 8'h60 + 8'(i), 1);
    rchk("pp_cnt7", 16'h0075, 8'h04);
    push(2, 8'h69, 1);
    rchk("pp_cnt8", 16'h0075, 8'h06);
    // flush while 8'h61 is on the wire
    wr(8'h75, 8'h01);
    rchk("flush_status", 16'h0075, 8'h05);
    sb[2].delete();
    auto_en[2] = 1'b1;
    cycles(8);
    chk("flush_data", 32'(ch_data[23:16]), 'h61);
    rchk("flush_idle", 16'h0075, 8'h01);
    // pointer wrap over 20 bytes on channel 0
    lat = '{2, 1, 1, 1};
    for (int i = 0; i < 20; i++) begin
      push(0, 8'(i * 7 + 3), 1);
      cycles(5);
    end
    drain("wrap");
    // disabled block ignores writes and reads back 8'hFF
    enable = 1'b0;
    wr(8'h70, 8'hEE);
    rchk("dis_dout", 16'h0071, 8'hFF);
    enable = 1'b1;
    cycles(4);
    chk("dis_nostrobe", 32'(ch_strobe), 0);
    rchk("dis_status", 16'h0071, 8'h01);
    // asynchronous reset in the middle of a strobe
    auto_en = 4'h0;
    push(0, 8'h5A, 1);
    @(negedge clk_sys);
    chk("arst_pre", 32'(ch_strobe[0]), 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_strobe", 32'(ch_strobe), 0);
    chk("arst_data", ch_data, 0);
    @(negedge clk_sys);
    reset = 1'b0;
    rchk("arst_status", 16'h0071, 8'h01);
    auto_en = 4'hF;
    push(0, 8'h77, 1);
    drain("resume");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
